// File: rtl/alu_src_b_stage_if.sv
// ALU B-operand stage bus: source/select input channel, elastic output
// channel and the sticky select-error flag with its clear.
// The master modport is the upstream/ALU side, the slave modport is the stage.
interface alu_src_b_stage_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 5,
    parameter int SEL_W   = 3
);
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]         sel;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     sel_err;
    logic                     err_clr;

    modport master (
        output src_data,
        output sel,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  sel_err,
        output err_clr
    );

    modport slave (
        input  src_data,
        input  sel,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output sel_err,
        input  err_clr
    );
endinterface

// File: rtl/alu_src_b_stage.sv
// ALU B-operand select stage.
// Picks one of NUM_SRC operand sources (one index may be replaced by the
// hardwired CONST_VAL), registers it into a 2-entry valid/ready elastic
// buffer (head + skid) so the ALU can stall without losing an operand.
// Out-of-range selects push zero and raise a sticky sel_err.
// Optional feature macro: ALU_SRC_B_ERR_CNT_EN adds an 8-bit saturating
// count of out-of-range pushes on port err_cnt.
module alu_src_b_stage #(
    parameter int WIDTH     = 32,
    parameter int NUM_SRC   = 5,
    parameter int SEL_W     = 3,
    parameter int CONST_SEL = 1,
    parameter int CONST_VAL = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_src_b_stage_if.slave  bus
`ifdef ALU_SRC_B_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    // A CONST_SEL outside the source range disables the constant path.
    localparam bit               CONST_EN = (CONST_SEL < NUM_SRC);
    localparam logic [WIDTH-1:0] CONST_W  = WIDTH'(CONST_VAL);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_t;

    fill_t            state;
    fill_t            state_next;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;
    logic [WIDTH-1:0] head_next;
    logic [WIDTH-1:0] skid_next;
    logic [WIDTH-1:0] sel_val;
    logic [31:0]      sel_idx;
    logic             sel_oor;
    logic             in_ready_int;
    logic             out_valid_int;
    logic             push;
    logic             pop;
    logic             err_q;

    // Handshake flags come from the registered fill state only, so there is
    // no combinational path from out_ready to in_ready.
    assign in_ready_int  = (state != FULL);
    assign out_valid_int = (state != EMPTY);
    assign push          = bus.in_valid && in_ready_int;
    assign pop           = out_valid_int && bus.out_ready;

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_data  = head;
    assign bus.sel_err   = err_q;

    // Operand mux: constant override first, then the source slices, and
    // anything beyond the last source becomes zero plus an error flag.
    always_comb begin
        sel_idx = 32'(bus.sel);
        sel_val = '0;
        sel_oor = 1'b0;
        if (CONST_EN && (sel_idx == 32'(CONST_SEL))) begin
            sel_val = CONST_W;
        end else if (sel_idx < 32'(NUM_SRC)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (sel_idx == 32'(i)) begin
                    sel_val = bus.src_data[i*WIDTH +: WIDTH];
                end
            end
        end else begin
            sel_oor = 1'b1;
        end
    end

    // Fill-state next-state logic and head/skid entry updates.
    always_comb begin
        state_next = state;
        head_next  = head;
        skid_next  = skid;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next = ONE;
                    head_next  = sel_val;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_next = sel_val;
                end else if (push) begin
                    state_next = FULL;
                    skid_next  = sel_val;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_next = ONE;
                    head_next  = skid;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Fill state and buffer entries; reset discards both entries at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_next;
            head  <= head_next;
            skid  <= skid_next;
        end
    end

    // Sticky select error: an out-of-range push wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (push && sel_oor) begin
            err_q <= 1'b1;
        end else if (bus.err_clr) begin
            err_q <= 1'b0;
        end
    end

`ifdef ALU_SRC_B_ERR_CNT_EN
    // Saturating count of out-of-range pushes; clear plus increment gives 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= 8'd0;
        end else if (bus.err_clr) begin
            err_cnt <= (push && sel_oor) ? 8'd1 : 8'd0;
        end else if (push && sel_oor && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Testbench for alu_src_b_stage: table-driven single-transaction vectors,
// hand-written stall/throughput/error/async-reset sequences, and random
// traffic checked against a queue-based reference model.
module tb_alu_src_b_stage;

    localparam int WIDTH     = 32;
    localparam int NUM_SRC   = 5;
    localparam int SEL_W     = 3;
    localparam int CONST_SEL = 1;
    localparam int CONST_VAL = 4;

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [31:0]      exp_data;
        logic             exp_err;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] src [NUM_SRC];
    int          tests_run;
    int          tests_failed;

    logic [31:0] mq[$];
    bit          m_err;
    int          m_cnt;
    vec_t        vecs [8];

`ifdef ALU_SRC_B_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    alu_src_b_stage_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

    alu_src_b_stage #(
        .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W),
        .CONST_SEL(CONST_SEL), .CONST_VAL(CONST_VAL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef ALU_SRC_B_ERR_CNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference selection rule.
    function automatic logic [31:0] ref_value(input logic [SEL_W-1:0] s);
        if (int'(s) == CONST_SEL) return 32'(CONST_VAL);
        if (int'(s) < NUM_SRC) return src[int'(s)];
        return 32'd0;
    endfunction

    function automatic bit ref_oor(input logic [SEL_W-1:0] s);
        return (int'(s) >= NUM_SRC);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input bit valid, input logic [SEL_W-1:0] s, input bit rdy, input bit clr);
        for (int i = 0; i < NUM_SRC; i++) bus.src_data[i*WIDTH +: WIDTH] = src[i];
        bus.in_valid  = valid;
        bus.sel       = s;
        bus.out_ready = rdy;
        bus.err_clr   = clr;
    endtask

    // Advance one clock, update the model from the inputs that were present
    // at the edge, then compare every DUT output against the model.
    task automatic tick();
        bit          push;
        bit          pop;
        bit          oor;
        logic [31:0] v;
        push = bus.in_valid && (mq.size() < 2);
        pop  = (mq.size() > 0) && bus.out_ready;
        v    = ref_value(bus.sel);
        oor  = push && ref_oor(bus.sel);
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(v);
        if (oor) begin
            m_err = 1'b1;
            m_cnt = bus.err_clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
        end else if (bus.err_clr) begin
            m_err = 1'b0;
            m_cnt = 0;
        end
        check_output("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        check_output("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
        if (mq.size() != 0) check_output("out_data", bus.out_data, mq[0]);
        check_output("sel_err", 32'(bus.sel_err), 32'(m_err));
`ifdef ALU_SRC_B_ERR_CNT_EN
        check_output("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_err        = 1'b0;
        m_cnt        = 0;
        src[0] = 32'h0000_0001;
        src[1] = 32'hDEAD_BEEF;
        src[2] = 32'h0000_0003;
        src[3] = 32'h0000_0004;
        src[4] = 32'hA5A5_5A5A;

        vecs[0] = '{sel: 3'd0, exp_data: 32'h0000_0001, exp_err: 1'b0};
        vecs[1] = '{sel: 3'd1, exp_data: 32'h0000_0004, exp_err: 1'b0};
        vecs[2] = '{sel: 3'd2, exp_data: 32'h0000_0003, exp_err: 1'b0};
        vecs[3] = '{sel: 3'd3, exp_data: 32'h0000_0004, exp_err: 1'b0};
        vecs[4] = '{sel: 3'd4, exp_data: 32'hA5A5_5A5A, exp_err: 1'b0};
        vecs[5] = '{sel: 3'd5, exp_data: 32'h0000_0000, exp_err: 1'b1};
        vecs[6] = '{sel: 3'd6, exp_data: 32'h0000_0000, exp_err: 1'b1};
        vecs[7] = '{sel: 3'd7, exp_data: 32'h0000_0000, exp_err: 1'b1};

        // Reset state.
        reset = 1'b1;
        apply_stimulus(0, 3'd0, 1, 0);
        #2 reset = 1'b0;
        #1;
        check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("rst_out_data", bus.out_data, 32'd0);
        check_output("rst_sel_err", 32'(bus.sel_err), 32'd0);
`ifdef ALU_SRC_B_ERR_CNT_EN
        check_output("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        #17 reset = 1'b1;

        // Table: one push from empty, check, then pop and clear.
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1, vecs[k].sel, 1, 0);
            tick();
            check_output("vec_valid", 32'(bus.out_valid), 32'd1);
            check_output("vec_data", bus.out_data, vecs[k].exp_data);
            check_output("vec_err", 32'(bus.sel_err), 32'(vecs[k].exp_err));
            apply_stimulus(0, 3'd0, 1, 1);
            tick();
        end

        // Stall: two pushes fill the buffer, head held while not ready.
        apply_stimulus(1, 3'd2, 0, 0);
        tick();
        apply_stimulus(1, 3'd3, 0, 0);
        tick();
        check_output("stall_in_ready", 32'(bus.in_ready), 32'd0);
        apply_stimulus(1, 3'd4, 0, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_output("stall_hold", bus.out_data, 32'd3);
        end
        apply_stimulus(0, 3'd0, 1, 0);
        tick();
        check_output("stall_pop1", bus.out_data, 32'd4);
        tick();
        check_output("stall_empty", 32'(bus.out_valid), 32'd0);

        // Throughput: push every cycle, sel cycling through all sources.
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(1, 3'(k % NUM_SRC), 1, 0);
            tick();
            check_output("thru_in_ready", 32'(bus.in_ready), 32'd1);
            check_output("thru_data", bus.out_data, ref_value(3'(k % NUM_SRC)));
        end
        apply_stimulus(0, 3'd0, 1, 0);
        tick();

        // Error flag: set, sticky, clear, set-wins-over-clear.
        apply_stimulus(1, 3'd6, 1, 0);
        tick();
        check_output("err_data", bus.out_data, 32'd0);
        apply_stimulus(0, 3'd0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_output("err_sticky", 32'(bus.sel_err), 32'd1);
        end
        apply_stimulus(0, 3'd0, 1, 1);
        tick();
        check_output("err_cleared", 32'(bus.sel_err), 32'd0);
        apply_stimulus(1, 3'd7, 1, 1);
        tick();
        check_output("err_set_wins", 32'(bus.sel_err), 32'd1);
`ifdef ALU_SRC_B_ERR_CNT_EN
        check_output("cnt_set_wins", 32'(err_cnt), 32'd1);
        apply_stimulus(1, 3'd5, 1, 0);
        for (int k = 0; k < 260; k++) tick();
        check_output("cnt_saturate", 32'(err_cnt), 32'd255);
`endif
        apply_stimulus(0, 3'd0, 1, 1);
        tick();

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NUM_SRC; i++) src[i] = $urandom;
            apply_stimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            tick();
        end

        // Async reset while full and with the error flag set.
        apply_stimulus(0, 3'd0, 1, 1);
        tick();
        tick();
        apply_stimulus(1, 3'd6, 0, 0);
        tick();
        apply_stimulus(1, 3'd2, 0, 0);
        tick();
        check_output("ar_full", 32'(bus.in_ready), 32'd0);
        apply_stimulus(0, 3'd0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check_output("ar_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("ar_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("ar_out_data", bus.out_data, 32'd0);
        check_output("ar_sel_err", 32'(bus.sel_err), 32'd0);
        mq.delete();
        m_err = 1'b0;
        m_cnt = 0;
        #2 reset = 1'b1;
        apply_stimulus(1, 3'd4, 1, 0);
        tick();
        check_output("ar_first_push", bus.out_data, src[4]);
        apply_stimulus(0, 3'd0, 1, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_src_b_stage.md
Name: alu_src_b_stage

Overview:
Parametrised successor to the ALU B-operand select. Selects one of NUM_SRC operand sources, with one source replaceable by a hardwired constant (the old "select 4" path), and registers the result. The registered result passes through a 2-entry valid/ready elastic buffer. Sits between the register-file/immediate datapath and ALU input B, so the control unit can stall the ALU without losing a selected operand.

Parameters:
WIDTH, 32, operand width in bits
NUM_SRC, 5, number of selectable sources (index 0..NUM_SRC-1)
SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_SRC
CONST_SEL, 1, source index replaced by CONST_VAL; set >= NUM_SRC to disable
CONST_VAL, 4, constant driven when sel == CONST_SEL

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
src_data  in  NUM_SRC*WIDTH  flattened sources; source i at bits [i*WIDTH +: WIDTH]
sel  in  SEL_W  source select (ALUSrcB)
in_valid  in  1  sel and src_data valid this cycle
in_ready  out  1  stage can accept
out_data  out  WIDTH  selected operand to ALU B
out_valid  out  1  out_data valid
out_ready  in  1  ALU consumes out_data
sel_err  out  1  sticky: out-of-range sel was accepted
err_clr  in  1  clears sel_err

Behaviour:
- Reset (reset == 0, asynchronous): fill = EMPTY; out_valid = 0; out_data = 0; both buffer entries = 0; sel_err = 0; in_ready = 1.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- Selection at push:
  - sel == CONST_SEL → CONST_VAL, zero-extended or truncated to WIDTH.
  - sel < NUM_SRC → the selected src_data slice.
  - sel >= NUM_SRC → 0, and sel_err is set.
- Latency: a value pushed in cycle N appears on out_data with out_valid = 1 in cycle N+1 if the stage was empty or popping.
- Fill states: EMPTY (0 entries), ONE (1), FULL (2). in_ready = (state != FULL), decoded from registered state only; no combinational path from out_ready.
- Transitions:
  - EMPTY + push → ONE.
  - ONE + push, no pop → FULL.
  - ONE + pop, no push → EMPTY.
  - ONE + push + pop → ONE; the new value replaces the head.
  - FULL + pop → ONE; the skid entry moves to the head.
  - FULL: push is impossible.
- Ordering is strict FIFO. out_valid = (state != EMPTY). out_data is the head entry.
- While out_valid && !out_ready, out_data must not change.
- in_valid while in_ready == 0: ignored, no state change. Upstream holds its data.
- sel_err priority: if err_clr and an out-of-range push occur in the same cycle, set wins and sel_err = 1 next cycle. Otherwise err_clr clears it the next cycle.
- sel and src_data are sampled only on push. Changes while not pushing have no effect.
- Reset asserted mid-transfer discards both entries immediately. The first push after reset release behaves as from EMPTY.

Optional Feature:
Macro ALU_SRC_B_ERR_CNT_EN.
- Defined: adds output err_cnt (8 bits), reset 0. It increments on every out-of-range push and saturates at 255. err_clr zeroes it. If a clear and an increment coincide, the result is 1.
- Undefined: port and counter are absent; sel_err behaves identically in both builds.

Test Plan:
- Reset, then in_valid=1, sel=0, src0=0x00000001, out_ready=1 → next cycle out_valid=1, out_data=0x00000001; reset state shows in_ready=1, out_data=0.
- sel=1 (CONST_SEL) with src1=0xDEADBEEF → out_data=0x00000004, not 0xDEADBEEF.
- Stall: out_ready=0, push sel=2 (src2=3) then sel=3 (src3=4) → in_ready=0 after the second push, out_data held at 3 for 5 cycles. Raise out_ready → 3 popped, then 4, then out_valid=0.
- Throughput: out_ready=1, push every cycle with sel cycling 0..4 → one output per cycle in order with 1-cycle latency; in_ready stays 1.
- Error: push sel=6 → out_data=0, sel_err=1 and stays 1. Pulse err_clr → sel_err=0. err_clr together with another sel=7 push → sel_err=1; with ALU_SRC_B_ERR_CNT_EN, err_cnt=1.
- Async reset: assert reset mid-cycle while FULL → out_valid=0 and in_ready=1 without waiting for a clock edge.
